// File: rtl/pipe_mux_tree.sv
// Purpose: N-to-1 word selector built as a binary mux tree, one tree level per select bit.
// Latency: SEL_BITS cycles when PIPELINED=1, 1 cycle when PIPELINED=0.
// Backpressure: the whole pipe advances only when the output is empty or consumed; in_ready mirrors that.
//
// Ports:
//   clk, reset          single clock, synchronous active-high reset
//   iData, Ctrl         flat N*WIDTH input bus and index of the word to forward
//   in_valid/in_ready   input handshake
//   oData, oCtrl        selected word and the Ctrl value that produced it
//   out_valid/out_ready output handshake
//   xfer_count          saturating count of completed output transfers
module pipe_mux_tree #(
    parameter int WIDTH     = 32,
    parameter int SEL_BITS  = 3,
    parameter int PIPELINED = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [(WIDTH<<SEL_BITS)-1:0]  iData,
    input  logic [SEL_BITS-1:0]           Ctrl,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [WIDTH-1:0]              oData,
    output logic [SEL_BITS-1:0]           oCtrl,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [15:0]                   xfer_count
);

    localparam int N = 1 << SEL_BITS;

    // Every stage moves together; a stalled output freezes the whole pipe,
    // bubbles included, so nothing is collapsed or reordered.
    logic w_adv;
    assign w_adv    = out_ready || !out_valid;
    assign in_ready = w_adv;

    genvar k, j;
    for (k = 0; k < SEL_BITS; k++) begin : g_lvl
        // Level k halves the word count, steering with select bit k.
        localparam int NW     = N >> (k + 1);
        localparam bit IS_REG = (PIPELINED != 0) || (k == SEL_BITS - 1);

        logic [2*NW*WIDTH-1:0] w_in_dat;
        logic                  w_in_vld;
        logic [SEL_BITS-1:0]   w_in_ctl;
        logic [NW*WIDTH-1:0]   w_sel_dat;
        logic [NW*WIDTH-1:0]   w_out_dat;
        logic                  w_out_vld;
        logic [SEL_BITS-1:0]   w_out_ctl;

        if (k == 0) begin : g_src
            assign w_in_dat = iData;
            assign w_in_vld = in_valid;
            assign w_in_ctl = Ctrl;
        end else begin : g_src
            assign w_in_dat = g_lvl[k-1].w_out_dat;
            assign w_in_vld = g_lvl[k-1].w_out_vld;
            assign w_in_ctl = g_lvl[k-1].w_out_ctl;
        end

        for (j = 0; j < NW; j++) begin : g_pair
            assign w_sel_dat[j*WIDTH +: WIDTH] = w_in_ctl[k] ? w_in_dat[(2*j+1)*WIDTH +: WIDTH]
                                                             : w_in_dat[(2*j)*WIDTH +: WIDTH];
        end

        if (IS_REG) begin : g_reg
            // The full original Ctrl travels with the data: bits above k are
            // the still-unresolved selects, and the whole value becomes oCtrl.
            logic                r_vld;
            logic [NW*WIDTH-1:0] r_dat;
            logic [SEL_BITS-1:0] r_ctl;

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_vld <= 1'b0;
                    r_dat <= '0;
                    r_ctl <= '0;
                end else if (w_adv) begin
                    r_vld <= w_in_vld;
                    r_dat <= w_sel_dat;
                    r_ctl <= w_in_ctl;
                end
            end

            assign w_out_vld = r_vld;
            assign w_out_dat = r_dat;
            assign w_out_ctl = r_ctl;
        end else begin : g_comb
            assign w_out_vld = w_in_vld;
            assign w_out_dat = w_sel_dat;
            assign w_out_ctl = w_in_ctl;
        end
    end

    assign out_valid = g_lvl[SEL_BITS-1].w_out_vld;
    assign oData     = g_lvl[SEL_BITS-1].w_out_dat;
    assign oCtrl     = g_lvl[SEL_BITS-1].w_out_ctl;

    logic [15:0] r_xfer_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_xfer_count <= 16'd0;
        end else if (out_valid && out_ready && (r_xfer_count != 16'hFFFF)) begin
            r_xfer_count <= r_xfer_count + 16'd1;
        end
    end

    assign xfer_count = r_xfer_count;

endmodule

// File: doc/pipe_mux_tree.md
PIPE_MUX_TREE -- requirements
Module: pipe_mux_tree

Interface
REQ-001 Parameter WIDTH, default 32: data width of each input and of the output, in bits.
REQ-002 Parameter SEL_BITS, default 3: number of select bits; input count N = 2**SEL_BITS; legal range 1..5.
REQ-003 Parameter PIPELINED, default 1: 1 = register after every tree level, latency L = SEL_BITS; 0 = combinational tree plus one output register, L = 1.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port iData, input, N*WIDTH bits: flat input bus; input i occupies bits [i*WIDTH +: WIDTH].
REQ-007 Port Ctrl, input, SEL_BITS bits: index of the input to forward; sampled with iData.
REQ-008 Port in_valid, input, 1 bit: iData and Ctrl are valid this cycle.
REQ-009 Port in_ready, output, 1 bit: the block accepts a sample this cycle.
REQ-010 Port oData, output, WIDTH bits: the selected data word.
REQ-011 Port oCtrl, output, SEL_BITS bits: the Ctrl value that produced oData.
REQ-012 Port out_valid, output, 1 bit: oData and oCtrl are valid.
REQ-013 Port out_ready, input, 1 bit: the downstream consumer accepts oData this cycle.
REQ-014 Port xfer_count, output, 16 bits: count of completed output transfers, saturating.

Function
REQ-015 An input transfer occurs on a clock edge where in_valid && in_ready; an output transfer occurs on a clock edge where out_valid && out_ready.
REQ-016 The pipeline advance enable SHALL be adv = out_ready || !out_valid, and in_ready SHALL equal adv combinationally.
REQ-017 When adv = 1, every stage loads from its predecessor, and stage 0 loads {in_valid, iData, Ctrl}; when adv = 0, every stage holds its contents.
REQ-018 Tree level k (k = 0..SEL_BITS-1) pairs adjacent words 2j and 2j+1 and selects word 2j+1 when select bit k = 1; bit 0 resolves at the first level and the MSB at the last.
REQ-019 With PIPELINED = 1, each stage registers its partial words, a valid bit, the original Ctrl (forwarded to oCtrl), and the unresolved select bits.
REQ-020 With PIPELINED = 0, the full tree resolves combinationally and only the output register holds state.
REQ-021 Bubbles (valid = 0) propagate as ordinary stages; they are not collapsed, so throughput is 1 sample per cycle while out_ready = 1.
REQ-022 oData = iData[Ctrl*WIDTH +: WIDTH] of the accepted sample, exactly L advancing edges after its acceptance; sample order is preserved.
REQ-023 While out_valid = 1 and out_ready = 0, oData, oCtrl and out_valid SHALL be stable.
REQ-024 xfer_count increments by 1 on each output transfer and holds at 16'hFFFF once reached.
REQ-025 Data in stages whose valid bit is 0 is don't-care internally; oData is not checked while out_valid = 0.

Reset
REQ-026 When reset = 1 at a clock edge, all stage valid bits, out_valid, oData, oCtrl and xfer_count are cleared to 0, and any in-flight samples are discarded.
REQ-027 reset has priority over a simultaneous input or output transfer; a sample offered in the reset cycle is not accepted, and the count does not increment.
REQ-028 in_ready = 1 in the first cycle after reset is released.

Verification
REQ-029 Defaults: iData[i] = 32'h1000_0000+i, Ctrl = 0..7 on consecutive cycles, out_ready = 1 -> oData = 32'h1000_0000..32'h1000_0007 beginning 3 cycles later, oCtrl matches, xfer_count = 8.
REQ-030 Backpressure: out_ready = 0 for 5 cycles with the pipeline full -> in_ready = 0, outputs frozen; after release, no sample is lost or duplicated.
REQ-031 PIPELINED = 0, SEL_BITS = 1, Ctrl = 1, iData = {32'hDEAD_BEEF, 32'h0} -> oData = 32'hDEAD_BEEF with out_valid = 1 one cycle later.
REQ-032 Reset asserted for 1 cycle with 2 samples in flight -> out_valid = 0 and xfer_count = 0 on the next cycle; neither sample ever appears.
REQ-033 Saturation: force 65 540 output transfers -> xfer_count stops at 16'hFFFF.
REQ-034 Random stimulus (in_valid and out_ready each 50 %, SEL_BITS = 5, WIDTH = 8) -> the output stream matches the reference-model queue in order.
